// File: rtl/simd_mem_access_unit.sv
// -----------------------------------------------------------------------------
// simd_mem_access_unit
//
// Initiator side of the SIMD data-memory port. Accepts multi-beat vector
// load/store requests from execute and turns them into one memory access per
// beat. The memory has a 1-cycle registered read and LANES-wide data.
//
// Ports:
//   clk_i, rst_i            clock and synchronous active-high reset
//   req_valid_i/req_ready_o request handshake (ready only when idle)
//   req_write_i             1 = store, 0 = load
//   req_addr_i              address of beat 0
//   req_beats_i             beat count, values above MAX_BEATS are clamped
//   wr_valid_i/wr_ready_o   store beat handshake, wr_data_i is the beat data
//   rd_valid_o/rd_data_o    load beat return, one beat per cycle, no stall
//   rd_last_o               final load beat marker
//   done_o                  1-cycle pulse at request completion
//   mem_we_o/mem_addr_o     memory write enable and beat address
//   mem_wdata_o/mem_rdata_i memory write and read data
// -----------------------------------------------------------------------------
module simd_mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int LANES       = 4,
    parameter int MAX_BEATS   = 8,
    parameter int BEAT_W      = $clog2(MAX_BEATS + 1),
    parameter int BEAT_STRIDE = 16 * LANES
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [ADDR_W-1:0]         req_addr_i,
    input  logic [BEAT_W-1:0]         req_beats_i,
    input  logic                      wr_valid_i,
    output logic                      wr_ready_o,
    input  logic [LANES*DATA_W-1:0]   wr_data_i,
    output logic                      rd_valid_o,
    output logic [LANES*DATA_W-1:0]   rd_data_o,
    output logic                      rd_last_o,
    output logic                      done_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [LANES*DATA_W-1:0]   mem_wdata_o,
    input  logic [LANES*DATA_W-1:0]   mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2,
        WR       = 2'd3
    } state_e;

    state_e                    state_q;
    logic [ADDR_W-1:0]         addr_q;
    logic [BEAT_W-1:0]         beats_q;
    logic [BEAT_W-1:0]         cnt_q;
    // Stage 1: a read was issued last cycle, mem_rdata_i holds it now.
    logic                      p1_valid_q;
    logic                      p1_last_q;
    // Stage 2: registered load return towards writeback.
    logic                      rd_valid_q;
    logic                      rd_last_q;
    logic [LANES*DATA_W-1:0]   rd_data_q;
    logic                      done_q;

    logic [BEAT_W-1:0]         req_beats_s;
    logic                      last_beat_s;

    // Clamp the requested beat count and flag the final beat of the request.
    always_comb begin
        req_beats_s = req_beats_i;
        if (req_beats_i > BEAT_W'(MAX_BEATS)) begin
            req_beats_s = BEAT_W'(MAX_BEATS);
        end else begin
            req_beats_s = req_beats_i;
        end
        last_beat_s = (cnt_q == (beats_q - BEAT_W'(1)));
    end

    // Request sequencer, load return pipeline and completion pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            beats_q    <= '0;
            cnt_q      <= '0;
            p1_valid_q <= 1'b0;
            p1_last_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            p1_valid_q <= 1'b0;
            p1_last_q  <= 1'b0;
            rd_valid_q <= p1_valid_q;
            rd_last_q  <= p1_valid_q & p1_last_q;
            // Load completion coincides with the final beat leaving stage 2.
            done_q     <= p1_valid_q & p1_last_q;
            if (p1_valid_q) begin
                rd_data_q <= mem_rdata_i;
            end else begin
                rd_data_q <= rd_data_q;
            end

            case (state_q)
                IDLE: begin
                    if (req_valid_i) begin
                        addr_q  <= req_addr_i;
                        beats_q <= req_beats_s;
                        cnt_q   <= '0;
                        if (req_beats_s == BEAT_W'(0)) begin
                            done_q <= 1'b1;
                        end else if (req_write_i) begin
                            state_q <= WR;
                        end else begin
                            state_q <= RD_ISSUE;
                        end
                    end
                end
                RD_ISSUE: begin
                    p1_valid_q <= 1'b1;
                    p1_last_q  <= last_beat_s;
                    addr_q     <= addr_q + ADDR_W'(BEAT_STRIDE);
                    cnt_q      <= cnt_q + BEAT_W'(1);
                    if (last_beat_s) begin
                        state_q <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (rd_valid_q && rd_last_q) begin
                        state_q <= IDLE;
                    end
                end
                WR: begin
                    if (wr_valid_i) begin
                        addr_q <= addr_q + ADDR_W'(BEAT_STRIDE);
                        cnt_q  <= cnt_q + BEAT_W'(1);
                        if (last_beat_s) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign wr_ready_o  = (state_q == WR);
    // Writes follow the store handshake directly; reset kills any write.
    assign mem_we_o    = (state_q == WR) && wr_valid_i && !rst_i;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wr_data_i;
    assign rd_valid_o  = rd_valid_q;
    assign rd_last_o   = rd_last_q;
    assign rd_data_o   = rd_data_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_simd_mem_access_unit.sv
module tb_simd_mem_access_unit;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [31:0]   req_addr;
    logic [3:0]    req_beats;
    logic          wr_valid, wr_ready;
    logic [127:0]  wr_data;
    logic          rd_valid, rd_last, done;
    logic [127:0]  rd_data;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [127:0]  mem_wdata, mem_rdata;

    int checks = 0;
    int failures = 0;

    logic [127:0]  exp_beat [8];
    logic [31:0]   mem [256];
    bit            mem_init = 1'b0;

    always #5 clk = ~clk;

    simd_mem_access_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_write_i (req_write),
        .req_addr_i  (req_addr),
        .req_beats_i (req_beats),
        .wr_valid_i  (wr_valid),
        .wr_ready_o  (wr_ready),
        .wr_data_i   (wr_data),
        .rd_valid_o  (rd_valid),
        .rd_data_o   (rd_data),
        .rd_last_o   (rd_last),
        .done_o      (done),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    // Data memory: word base = DataAdr>>4 per beat, registered read.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int w = 0; w < 256; w++) mem[w] <= 32'(w);
            mem_init <= 1'b1;
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++) mem[8'((mem_addr >> 4) + 32'(i))] <= mem_wdata[i*32 +: 32];
        end
        for (int i = 0; i < 4; i++) mem_rdata[i*32 +: 32] <= mem[8'((mem_addr >> 4) + 32'(i))];
    end

    // Expected beats for a region still holding its preload (value = word index).
    task automatic fill_preloaded(input logic [31:0] addr, input int nb);
        logic [31:0] a;
        for (int b = 0; b < nb; b++) begin
            a = addr + 32'(b * 64);
            for (int i = 0; i < 4; i++) exp_beat[b][i*32 +: 32] = 32'(8'((a >> 4) + 32'(i)));
        end
    endtask

    task automatic run_load(input logic [31:0] addr, input int beats, input string name);
        int nb;
        logic [31:0] ea;
        logic want;
        nb = (beats > 8) ? 8 : beats;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = addr; req_beats = 4'(beats);
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL %s_accept req_ready=%b want 1", name, req_ready); end
        for (int c = 1; c <= nb + 3; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            ea = addr + 32'((c - 1) * 64);
            if (c <= nb) begin
                checks++;
                if (mem_addr !== ea || mem_we !== 1'b0) begin
                    failures++; $display("FAIL %s_issue c=%0d mem_addr=%h we=%b want %h we=0", name, c, mem_addr, mem_we, ea);
                end
            end
            want = (c >= 3 && c <= nb + 2);
            checks++;
            if (rd_valid !== want) begin failures++; $display("FAIL %s_rd_valid c=%0d got %b want %b", name, c, rd_valid, want); end
            if (want) begin
                checks++;
                if (rd_data !== exp_beat[c-3]) begin failures++; $display("FAIL %s_rd_data c=%0d got %h want %h", name, c, rd_data, exp_beat[c-3]); end
            end
            want = (c == nb + 2);
            checks++;
            if (rd_last !== want || done !== want) begin
                failures++; $display("FAIL %s_last_done c=%0d rd_last=%b done=%b want %b", name, c, rd_last, done, want);
            end
            want = (c == nb + 3);
            checks++;
            if (req_ready !== want) begin failures++; $display("FAIL %s_req_ready c=%0d got %b want %b", name, c, req_ready, want); end
        end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got %b want 0", mem_we); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || wr_ready !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL reset_flags rdy=%b wrdy=%b rv=%b rl=%b done=%b want 1 0 0 0 0", req_ready, wr_ready, rd_valid, rd_last, done);
        end
        checks++;
        if (rd_data !== 128'd0 || mem_addr !== 32'd0) begin
            failures++; $display("FAIL reset_regs rd_data=%h mem_addr=%h want 0 0", rd_data, mem_addr);
        end
    endtask

    task automatic test_load3();
        fill_preloaded(32'h40, 3);
        run_load(32'h40, 3, "load3");
    endtask

    task automatic test_wrap();
        fill_preloaded(32'hFFFF_FFC0, 2);
        run_load(32'hFFFF_FFC0, 2, "wrap");
    endtask

    task automatic test_beats0();
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h500; req_beats = 4'd0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL beats0_accept rdy=%b done=%b want 1 0", req_ready, done); end
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (done !== (c == 1) || req_ready !== 1'b1 || mem_we !== 1'b0 || rd_valid !== 1'b0) begin
                failures++; $display("FAIL beats0 c=%0d done=%b rdy=%b we=%b rv=%b want %b 1 0 0", c, done, req_ready, mem_we, rd_valid, (c == 1));
            end
        end
    endtask

    task automatic test_store_gap();
        logic [127:0] d0, d1;
        logic [3:0]   wv;
        logic [31:0]  wa;
        d0 = {32'hA003, 32'hA002, 32'hA001, 32'hA000};
        d1 = {32'hB003, 32'hB002, 32'hB001, 32'hB000};
        wv = 4'b1001;
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0; req_beats = 4'd2;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL store_accept req_ready=%b want 1", req_ready); end
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0;
            wr_valid = wv[c-1];
            wr_data = (c == 4) ? d1 : d0;
            @(negedge clk);
            wa = (c == 1) ? 32'h0 : 32'h40;
            checks++;
            if (mem_we !== wv[c-1] || mem_addr !== wa || wr_ready !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL store_beat c=%0d we=%b addr=%h wrdy=%b done=%b want %b %h 1 0", c, mem_we, mem_addr, wr_ready, done, wv[c-1], wa);
            end
            if (wv[c-1]) begin
                checks++;
                if (mem_wdata !== wr_data) begin failures++; $display("FAIL store_wdata c=%0d got %h want %h", c, mem_wdata, wr_data); end
            end
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || req_ready !== 1'b1 || wr_ready !== 1'b0 || mem_we !== 1'b0) begin
            failures++; $display("FAIL store_done done=%b rdy=%b wrdy=%b we=%b want 1 1 0 0", done, req_ready, wr_ready, mem_we);
        end
        exp_beat[0] = d0;
        exp_beat[1] = d1;
        run_load(32'h0, 2, "store_readback");
    endtask

    task automatic test_clamp();
        fill_preloaded(32'h200, 8);
        run_load(32'h200, 15, "clamp");
    endtask

    task automatic test_reset_wr();
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h300; req_beats = 4'd4;
        @(posedge clk); #1;
        req_valid = 1'b0; wr_valid = 1'b1; wr_data = {4{32'hC0DE}};
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h300) begin failures++; $display("FAIL rstwr_beat0 we=%b addr=%h want 1 300", mem_we, mem_addr); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0) begin failures++; $display("FAIL rstwr_we_in_reset got %b want 0", mem_we); end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1 || done !== 1'b0 || mem_we !== 1'b0 || wr_ready !== 1'b0) begin
                failures++; $display("FAIL rstwr_after c=%0d rdy=%b done=%b we=%b wrdy=%b want 1 0 0 0", c, req_ready, done, mem_we, wr_ready);
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset_load();
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_beats = 4'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            checks++;
            if (rd_valid !== 1'b0 || rd_last !== 1'b0 || done !== 1'b0 || req_ready !== 1'b1) begin
                failures++; $display("FAIL rstld_after c=%0d rv=%b rl=%b done=%b rdy=%b want 0 0 0 1", c, rd_valid, rd_last, done, req_ready);
            end
        end
        fill_preloaded(32'h80, 1);
        run_load(32'h80, 1, "rstld_new");
    endtask

    task automatic test_back_to_back();
        logic [127:0] d3;
        d3 = {32'hD003, 32'hD002, 32'hD001, 32'hD000};
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100; req_beats = 4'd1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_accept req_ready=%b want 1", req_ready); end
        @(posedge clk); #1;
        req_write = 1'b0; wr_valid = 1'b1; wr_data = d3;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h100 || req_ready !== 1'b0) begin
            failures++; $display("FAIL b2b_store we=%b addr=%h rdy=%b want 1 100 0", mem_we, mem_addr, req_ready);
        end
        @(posedge clk); #1;
        wr_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || req_ready !== 1'b1) begin failures++; $display("FAIL b2b_store_done done=%b rdy=%b want 1 1", done, req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || mem_addr !== 32'h100 || mem_we !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL b2b_load_issue rdy=%b addr=%h we=%b done=%b want 0 100 0 0", req_ready, mem_addr, mem_we, done);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_latency rd_valid=%b want 0", rd_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (rd_valid !== 1'b1 || rd_last !== 1'b1 || done !== 1'b1 || rd_data !== d3) begin
            failures++; $display("FAIL b2b_load_data rv=%b rl=%b done=%b data=%h want 1 1 1 %h", rd_valid, rd_last, done, rd_data, d3);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL b2b_end rdy=%b rv=%b want 1 0", req_ready, rd_valid); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_beats = 4'd0;
        wr_valid = 1'b0; wr_data = 128'd0;
        test_reset();
        test_load3();
        test_wrap();
        test_beats0();
        test_store_gap();
        test_clamp();
        test_reset_wr();
        test_reset_load();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
